// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_seq_pkg;

   typedef enum logic [1:0] {
      PLLRST    = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_state_t;

   localparam int LOST_CNT_W = 8;

   // Larger of two elaboration-time integers; used to size the shared counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// N-stage single-bit synchronizer, synchronous active-high reset.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [N-1:0] ff;

   // Shift the asynchronous input through N flops; reset clears every stage.
   always_ff @(posedge clk) begin
      if (reset) ff <= '0;
      else       ff <= {ff[N-2:0], d};
   end

   assign q = ff[N-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL RESET, waits for a stable synchronized
// lock, then releases downstream reset. Re-arms on lock loss.
// Optional macro PLL_RESET_SEQ_TIMEOUT_EN: retry the PLL reset when lock does
// not arrive within LOCK_TIMEOUT cycles; without it WAIT_LOCK waits forever.
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT   = 65536
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lock,
   output logic                  pll_reset,
   output logic                  rst_out,
   output logic                  ready,
   output logic [LOST_CNT_W-1:0] lost_cnt
);

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
   localparam int CNT_MAX = max_int(max_int(PLL_RST_CYCLES, STABLE_CYCLES), LOCK_TIMEOUT);
`else
   localparam int CNT_MAX = max_int(PLL_RST_CYCLES, STABLE_CYCLES);
`endif
   localparam int CNT_W = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
`endif

   // Elaboration-time parameter range guards.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be 2..4");
   end
   if (PLL_RST_CYCLES < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
      $error("PLL_RST_CYCLES and STABLE_CYCLES must be >= 1");
   end
   if (LOCK_TIMEOUT < 2) begin : g_bad_tmo
      $error("LOCK_TIMEOUT must be >= 2");
   end

   pll_state_t            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [LOST_CNT_W-1:0] lost_nxt;
   logic                  lock_s;

   sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (lock),
      .q     (lock_s)
   );

   // Next state, counter and loss counter; every state change clears cnt.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      lost_nxt  = lost_cnt;
      unique case (state)
         PLLRST: begin
            if (cnt == RST_LAST) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
            else if (cnt == TMO_LAST) begin
               state_nxt = PLLRST;
               cnt_nxt   = '0;
            end
`else
            // No timeout: hold the counter so it can never wrap while waiting.
            else cnt_nxt = '0;
`endif
         end
         STABLE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            cnt_nxt = '0;
            if (!lock_s) begin
               state_nxt = PLLRST;
               if (lost_cnt != '1) lost_nxt = lost_cnt + LOST_CNT_W'(1);
            end
         end
         default: begin
            state_nxt = PLLRST;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and outputs; outputs decode next state so they move with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= PLLRST;
         cnt       <= '0;
         lost_cnt  <= '0;
         pll_reset <= 1'b1;
         rst_out   <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lost_cnt  <= lost_nxt;
         pll_reset <= (state_nxt == PLLRST);
         rst_out   <= (state_nxt != RUN);
         ready     <= (state_nxt == RUN);
      end
   end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: stimulus queues expected output
// changes (cycle + values); the monitor pops one per observed change.
module tb_pll_reset_seq;

   typedef struct {
      int         cyc;
      logic       pll;
      logic       rst;
      logic       rdy;
      logic [7:0] lost;
   } exp_t;

   exp_t sb[$];

   logic       clk = 1'b0;
   logic       reset, lock;
   logic       pll_reset, rst_out, ready;
   logic [7:0] lost_cnt;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   pll_reset_seq #(
      .SYNC_STAGES    (2),
      .PLL_RST_CYCLES (4),
      .STABLE_CYCLES  (8),
      .LOCK_TIMEOUT   (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .lock      (lock),
      .pll_reset (pll_reset),
      .rst_out   (rst_out),
      .ready     (ready),
      .lost_cnt  (lost_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input int c, input logic p, input logic r, input logic [7:0] l);
      exp_t e;
      e.cyc = c; e.pll = p; e.rst = r; e.rdy = ~r; e.lost = l;
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: checks invariants every cycle and each output change against the queue.
   initial begin : monitor
      logic [10:0] prev;
      logic [10:0] now;
      bit          first;
      exp_t        e;
      first = 1'b1;
      prev  = '0;
      forever begin
         @(posedge clk); #1;
         if (mon_en) begin
            now = {pll_reset, rst_out, ready, lost_cnt};
            checks++;
            if (rst_out !== ~ready || (pll_reset === 1'b1 && rst_out === 1'b0)) begin
               errors++;
               $display("FAIL invariant cyc=%0d got pll_reset=%b rst_out=%b ready=%b", cyc, pll_reset, rst_out, ready);
            end
            if (first || now !== prev) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_change cyc=%0d got pll=%b rst=%b rdy=%b lost=%0d, none expected",
                           cyc, pll_reset, rst_out, ready, lost_cnt);
               end else begin
                  e = sb.pop_front();
                  if (e.cyc != cyc || e.pll !== pll_reset || e.rst !== rst_out ||
                      e.rdy !== ready || e.lost !== lost_cnt) begin
                     errors++;
                     $display("FAIL event got cyc=%0d pll=%b rst=%b rdy=%b lost=%0d want cyc=%0d pll=%b rst=%b rdy=%b lost=%0d",
                              cyc, pll_reset, rst_out, ready, lost_cnt, e.cyc, e.pll, e.rst, e.rdy, e.lost);
                  end
               end
            end
            first = 1'b0;
            prev  = now;
         end
      end
   end

   // Bounded run time.
   initial begin : watchdog
      #150000;
      errors++;
      $display("FAIL watchdog cyc=%0d got no end of stimulus, want finish", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int l;
      reset = 1'b1;
      lock  = 1'b1;

      // Reset state, then release with lock tied high.
      wait_until(2);
      mon_en = 1'b1;
      push_exp(3, 1'b1, 1'b1, 8'd0);
      wait_until(3);
      reset = 1'b0;
      n = cyc;
      push_exp(n + 4,  1'b0, 1'b1, 8'd0);   // 4-cycle PLL reset
      push_exp(n + 13, 1'b0, 0, 8'd0);      // +1 WAIT_LOCK +8 STABLE

      // One-cycle lock drop in RUN: detected 2+1 edges later.
      wait_until(20);
      n = cyc;
      push_exp(n + 3,  1'b1, 1'b1, 8'd1);
      push_exp(n + 7,  1'b0, 1'b1, 8'd1);
      push_exp(n + 16, 1'b0, 1'b0, 8'd1);
      lock = 1'b0;
      @(negedge clk);
      lock = 1'b1;

      // Reset in RUN with lock low: clears lost_cnt, restarts PLL reset.
      wait_until(40);
      reset = 1'b1;
      lock  = 1'b0;
      push_exp(41, 1'b1, 1'b1, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      n = cyc;
      push_exp(n + 4, 1'b0, 1'b1, 8'd0);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
      // WAIT_LOCK re-entered at n+12 after the short pulse; retries every 4+32.
      push_exp(n + 44, 1'b1, 1'b1, 8'd0);
      push_exp(n + 48, 1'b0, 1'b1, 8'd0);
      push_exp(n + 80, 1'b1, 1'b1, 8'd0);
      push_exp(n + 84, 1'b0, 1'b1, 8'd0);
`endif
      // 3-cycle lock pulse: reaches STABLE, falls back without releasing reset.
      wait_until(n + 6);
      lock = 1'b1;
      wait_until(n + 9);
      lock = 1'b0;

      // Lock returns for good: STABLE at +3, RUN at +11.
      wait_until(n + 100);
      lock = 1'b1;
      push_exp(n + 111, 1'b0, 1'b0, 8'd0);

      // 300 lock losses: counter saturates at 255.
      for (int k = 1; k <= 300; k++) begin
         wait_until(160 + 20 * (k - 1));
         n = cyc;
         l = (k > 255) ? 255 : k;
         push_exp(n + 3,  1'b1, 1'b1, 8'(l));
         push_exp(n + 7,  1'b0, 1'b1, 8'(l));
         push_exp(n + 16, 1'b0, 1'b0, 8'(l));
         lock = 1'b0;
         @(negedge clk);
         lock = 1'b1;
      end

      // Reset while in RUN after saturation.
      wait_until(n + 20);
      reset = 1'b1;
      push_exp(n + 21, 1'b1, 1'b1, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      n = cyc;
      push_exp(n + 4,  1'b0, 1'b1, 8'd0);
      push_exp(n + 13, 1'b0, 1'b0, 8'd0);

      wait_until(n + 20);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover got %0d pending events want 0 (next cyc=%0d)", sb.size(), sb[0].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of lock synchronizer flops (allowed 2..4).
REQ-002 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_reset is held per reset attempt (allowed >=1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release (allowed >=1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536, cycles to wait for lock before retry (allowed >=2).
REQ-005 SHALL have port clk, input, 1 bit: free-running PLL reference clock (27 MHz crystal), never a PLL output.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port lock, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-008 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET pin, active-high.
REQ-009 SHALL have port rst_out, output, 1 bit: active-high reset for downstream logic; consumers re-synchronize it into PLL clock domains.
REQ-010 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-011 SHALL have port lost_cnt, output, 8 bits: count of lock losses seen in RUN.

Function
REQ-012 SHALL pass lock through SYNC_STAGES flops to form lock_s; all decisions use lock_s only.
REQ-013 SHALL implement states PLLRST, WAIT_LOCK, STABLE and RUN, plus one shared cycle counter that is cleared on every state entry.
REQ-014 PLLRST: pll_reset=1; after exactly PLL_RST_CYCLES cycles in the state -> WAIT_LOCK.
REQ-015 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE on the next edge.
REQ-016 STABLE: lock_s=0 -> WAIT_LOCK with no lost_cnt change; lock_s=1 for STABLE_CYCLES consecutive cycles in STABLE -> RUN.
REQ-017 RUN: lock_s=0 -> PLLRST on the next edge, and lost_cnt increments in the same edge.
REQ-018 lost_cnt SHALL saturate at 255 and never wrap.
REQ-019 rst_out SHALL be a registered output that is 1 in every state except RUN; ready SHALL equal NOT rst_out; both change on the same edge as the state register.
REQ-020 pll_reset SHALL be registered and SHALL be high for exactly PLL_RST_CYCLES cycles per PLLRST visit, glitch-free.
REQ-021 Outputs SHALL never have rst_out=0 while pll_reset=1.
REQ-022 Counter width SHALL be $clog2 of the largest of PLL_RST_CYCLES, STABLE_CYCLES and LOCK_TIMEOUT, plus 1; the counter SHALL never wrap inside a state.

Reset
REQ-023 On reset=1 at a clk edge: state=PLLRST, counter=0, synchronizer flops=0, pll_reset=1, rst_out=1, ready=0, lost_cnt=0.
REQ-024 Reset mid-operation, including during RUN, SHALL restart the PLLRST sequence and SHALL clear lost_cnt; it SHALL not increment lost_cnt.

Configuration
REQ-025 Macro PLL_RESET_SEQ_TIMEOUT_EN SHALL control the lock timeout.
REQ-026 With PLL_RESET_SEQ_TIMEOUT_EN defined: if WAIT_LOCK lasts LOCK_TIMEOUT cycles without lock_s=1, the next state SHALL be PLLRST (a retry); lost_cnt is unchanged.
REQ-027 With PLL_RESET_SEQ_TIMEOUT_EN undefined: WAIT_LOCK SHALL wait indefinitely, and LOCK_TIMEOUT SHALL be ignored for counter sizing.

Structure
REQ-028 Package pll_reset_seq_pkg SHALL hold the state enum (PLLRST, WAIT_LOCK, STABLE, RUN) and the localparam LOST_CNT_W=8.
REQ-029 Sub-module sync_ff SHALL be used: a parameterized N-stage single-bit synchronizer with synchronous active-high reset, instantiated once for lock.

Verification
REQ-030 Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32.
REQ-031 Reset release with lock tied 1 -> pll_reset high for exactly 4 cycles; rst_out falls exactly 1 (WAIT_LOCK) + 8 (STABLE) cycles after PLLRST exits; ready rises on the same edge; lost_cnt=0.
REQ-032 Lock pulse of 3 cycles during STABLE, then held low -> return to WAIT_LOCK; rst_out stays 1; lost_cnt stays 0.
REQ-033 In RUN, lock driven low for 1 cycle -> rst_out=1 and ready=0 on the same edge, 2+1 cycles after the drop; lost_cnt=1; pll_reset high for 4 cycles.
REQ-034 Macro defined, lock held 0 -> pll_reset pulses of 4 cycles repeat every 4+32 cycles; lost_cnt=0. Macro undefined -> exactly one 4-cycle pulse.
REQ-035 Force 300 lock losses in RUN -> lost_cnt reads 255 after the 255th loss and stays 255; assert reset in RUN -> lost_cnt=0 and pll_reset=1 on the next edge.
